// File: rtl/sha256_block_feeder.sv
// sha256_block_feeder: byte-stream front end for sha256_duct.
// Collects message bytes into 512-bit big-endian blocks, applies SHA-256
// padding (0x80 marker, zero fill, 64-bit bit length) and hands each block
// to the core through the ask / blk_valid / readout handshake.
// Optional macro SHA256_FEEDER_BLKCNT_EN adds blk_cnt, the zero-based index
// of the presented block within its message.
module sha256_block_feeder #(
  parameter int LEN_W = 64
) (
  input  logic         inclk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  input  logic         ask,
  output logic [511:0] block_n,
  output logic         blk_valid,
  output logic         readout
`ifdef SHA256_FEEDER_BLKCNT_EN
  ,
  output logic [15:0]  blk_cnt
`endif
);

  typedef enum logic [1:0] {FILL, PAD, HOLD} state_t;

  state_t             state_q;
  logic [6:0]         cnt_q;          // next byte index, 0..64
  logic [LEN_W-1:0]   len_q;          // running message length in bits
  logic               marker_done_q;  // 0x80 already written for this message
  logic               pad_pend_q;     // a padding-only block follows the held one
  logic [511:0]       block_q;
  logic               blk_valid_q;
  logic               readout_q;

  logic [511:0]       fill_blk_d;
  logic [511:0]       pad_blk_d;
  logic               place_marker_d;
  logic               pad_final_d;
  logic [63:0]        len64_d;

`ifdef SHA256_FEEDER_BLKCNT_EN
  logic [15:0]        blk_cnt_q;
  assign blk_cnt = blk_cnt_q;
`endif

  assign in_ready  = (state_q == FILL);
  assign block_n   = block_q;
  assign blk_valid = blk_valid_q;
  assign readout   = readout_q;

  // Next block contents for a byte write (FILL) and for the padding step (PAD).
  always_comb begin
    len64_d        = 64'(len_q);
    place_marker_d = !marker_done_q && (cnt_q < 7'd64);
    // A marker at index 55 or below leaves room for the length; a marker
    // from an earlier block means this is the pad-continuation block.
    pad_final_d    = (place_marker_d && (cnt_q <= 7'd55)) || marker_done_q;
    fill_blk_d     = block_q;
    pad_blk_d      = block_q;
    for (int i = 0; i < 64; i++) begin
      if (7'(i) == cnt_q) begin
        fill_blk_d[511-8*i -: 8] = in_data;
        pad_blk_d[511-8*i -: 8]  = place_marker_d ? 8'h80 : 8'h00;
      end else if (7'(i) > cnt_q) begin
        pad_blk_d[511-8*i -: 8]  = 8'h00;
      end
    end
    if (pad_final_d) begin
      pad_blk_d[63:0] = len64_d;
    end
  end

  // Control FSM with registered block and handshake outputs.
  always_ff @(posedge inclk) begin
    if (reset) begin
      state_q       <= FILL;
      cnt_q         <= 7'd0;
      len_q         <= '0;
      marker_done_q <= 1'b0;
      pad_pend_q    <= 1'b0;
      block_q       <= '0;
      blk_valid_q   <= 1'b0;
      readout_q     <= 1'b0;
`ifdef SHA256_FEEDER_BLKCNT_EN
      blk_cnt_q     <= 16'd0;
`endif
    end else begin
      case (state_q)
        FILL: begin
          if (in_valid) begin
            block_q <= fill_blk_d;
            cnt_q   <= cnt_q + 7'd1;
            len_q   <= len_q + LEN_W'(8);
            if (cnt_q == 7'd63) begin
              // Block is full: present it now. A final byte landing here
              // still needs a padding-only block afterwards.
              state_q     <= HOLD;
              blk_valid_q <= 1'b1;
              readout_q   <= 1'b0;
              pad_pend_q  <= in_last;
            end else if (in_last) begin
              state_q <= PAD;
            end
          end
        end
        PAD: begin
          block_q     <= pad_blk_d;
          if (place_marker_d) begin
            marker_done_q <= 1'b1;
          end
          readout_q   <= pad_final_d;
          pad_pend_q  <= !pad_final_d;
          blk_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (ask) begin
            blk_valid_q <= 1'b0;
            readout_q   <= 1'b0;
            cnt_q       <= 7'd0;
            block_q     <= '0;
            if (readout_q) begin
              len_q         <= '0;
              marker_done_q <= 1'b0;
              pad_pend_q    <= 1'b0;
              state_q       <= FILL;
`ifdef SHA256_FEEDER_BLKCNT_EN
              blk_cnt_q     <= 16'd0;
`endif
            end else begin
              state_q <= pad_pend_q ? PAD : FILL;
`ifdef SHA256_FEEDER_BLKCNT_EN
              if (blk_cnt_q != 16'hFFFF) begin
                blk_cnt_q <= blk_cnt_q + 16'd1;
              end
`endif
            end
          end
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_feeder.sv
// Self-checking bench for sha256_block_feeder: hand-written corner sequences
// plus a table of messages whose padded blocks come from a reference padder
// and are compared through a scoreboard queue.
module tb_sha256_block_feeder;

  logic         inclk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         ask;
  logic [511:0] block_n;
  logic         blk_valid;
  logic         readout;
`ifdef SHA256_FEEDER_BLKCNT_EN
  logic [15:0]  blk_cnt;
`endif

  always #5 inclk = ~inclk;

  sha256_block_feeder #(.LEN_W(64)) dut (
    .inclk     (inclk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .ask       (ask),
    .block_n   (block_n),
    .blk_valid (blk_valid),
    .readout   (readout)
`ifdef SHA256_FEEDER_BLKCNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  typedef struct {
    logic [511:0] blk;
    logic         ro;
    int           idx;
  } exp_t;

  typedef struct {
    int          pat;
    int          n;
    int          exp_blocks;
    logic [63:0] exp_len;
  } tv_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passed = 0;

  localparam logic [511:0] ABC_BLK = {24'h616263, 8'h80, 416'h0, 64'h18};
  localparam logic [511:0] XY_BLK  = {16'h7879, 8'h80, 424'h0, 64'h10};

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [7:0] msg_byte(input int pat, input int i);
    case (pat)
      0:       return 8'(8'h61 + i);
      1:       return 8'(97 + i / 4 + i % 4);
      default: return 8'(i * 7 + 3);
    endcase
  endfunction

  // Reference SHA-256 padder: message, 0x80, zeros to 56 mod 64, 64-bit length.
  task automatic push_expected(input int pat, input int n);
    logic [7:0]  m[$];
    logic [63:0] bl;
    exp_t        e;
    int          nb;
    bl = 64'(n) * 64'd8;
    for (int i = 0; i < n; i++) m.push_back(msg_byte(pat, i));
    m.push_back(8'h80);
    while ((m.size() % 64) != 56) m.push_back(8'h00);
    for (int k = 7; k >= 0; k--) m.push_back(bl[8*k +: 8]);
    nb = m.size() / 64;
    for (int b = 0; b < nb; b++) begin
      e.blk = '0;
      for (int j = 0; j < 64; j++) e.blk[511-8*j -: 8] = m[b*64+j];
      e.ro  = (b == nb - 1);
      e.idx = b;
      sbq.push_back(e);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_last  = 1'b0;
    ask      = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge inclk);
    idle_inputs();
    reset = 1'b1;
    @(negedge inclk);
    @(negedge inclk);
    reset = 1'b0;
  endtask

  // Stream one message, answering each presented block with ask.
  task automatic run_msg(input int pat, input int n, output int nblk, output logic [63:0] last_len);
    exp_t e;
    int   i = 0;
    int   cyc = 0;
    int   acc_cyc = -1;
    int   first_v = -1;
    int   lat_byte;
    bit   done = 0;
    nblk     = 0;
    last_len = '0;
    lat_byte = ((n < 64) ? n : 64) - 1;
    push_expected(pat, n);
    while (!done && cyc < 3000) begin
      @(negedge inclk);
      idle_inputs();
      cyc++;
      if (blk_valid) begin
        if (first_v < 0) first_v = cyc;
        if (sbq.size() == 0) begin
          fail_now($sformatf("extra_block n=%0d", n));
          done = 1;
        end else begin
          e = sbq.pop_front();
          chk($sformatf("block n=%0d b=%0d", n, e.idx), block_n, e.blk);
          chk($sformatf("readout n=%0d b=%0d", n, e.idx), 512'(readout), 512'(e.ro));
`ifdef SHA256_FEEDER_BLKCNT_EN
          chk($sformatf("blk_cnt n=%0d b=%0d", n, e.idx), 512'(blk_cnt), 512'(e.idx));
`endif
          nblk++;
          last_len = block_n[63:0];
          ask = 1'b1;
          if (e.ro) done = 1;
        end
      end else if (in_ready && i < n) begin
        in_data  = msg_byte(pat, i);
        in_valid = 1'b1;
        in_last  = (i == n - 1);
        if (i == lat_byte) acc_cyc = cyc;
        i++;
      end
    end
    @(negedge inclk);
    idle_inputs();
    if (!done) fail_now($sformatf("timeout n=%0d", n));
    chk($sformatf("latency n=%0d", n), 512'(first_v - acc_cyc), 512'((n >= 64) ? 1 : 2));
    chk($sformatf("released n=%0d", n), 512'({blk_valid, readout, in_ready}), 512'(3'b001));
    sbq.delete();
  endtask

  tv_t tv[8];
  int  nblk;
  logic [63:0] llen;

  initial begin
    tv[0] = '{pat: 0, n: 3,   exp_blocks: 1, exp_len: 64'h18};
    tv[1] = '{pat: 1, n: 56,  exp_blocks: 2, exp_len: 64'h1C0};
    tv[2] = '{pat: 2, n: 64,  exp_blocks: 2, exp_len: 64'h200};
    tv[3] = '{pat: 2, n: 55,  exp_blocks: 1, exp_len: 64'h1B8};
    tv[4] = '{pat: 2, n: 1,   exp_blocks: 1, exp_len: 64'h8};
    tv[5] = '{pat: 0, n: 119, exp_blocks: 2, exp_len: 64'h3B8};
    tv[6] = '{pat: 2, n: 120, exp_blocks: 3, exp_len: 64'h3C0};
    tv[7] = '{pat: 0, n: 3,   exp_blocks: 1, exp_len: 64'h18};

    idle_inputs();
    do_reset();
    // Reset state, sampled on the first cycle after reset deasserts.
    @(negedge inclk);
    chk("rst block_n", block_n, '0);
    chk("rst blk_valid", 512'(blk_valid), 512'(1'b0));
    chk("rst readout", 512'(readout), 512'(1'b0));
    chk("rst in_ready", 512'(in_ready), 512'(1'b1));

    // "abc" by hand: exact block, exact latency, hold stability, release.
    in_data = 8'h61; in_valid = 1'b1;
    @(negedge inclk); in_data = 8'h62;
    @(negedge inclk); in_data = 8'h63; in_last = 1'b1;
    @(negedge inclk); idle_inputs();
    chk("abc pad cycle blk_valid", 512'({blk_valid, in_ready}), 512'(2'b00));
    @(negedge inclk);
    chk("abc blk_valid", 512'(blk_valid), 512'(1'b1));
    chk("abc block", block_n, ABC_BLK);
    chk("abc readout", 512'(readout), 512'(1'b1));
    chk("abc in_ready", 512'(in_ready), 512'(1'b0));
    repeat (3) @(negedge inclk);
    chk("abc hold stable", block_n, ABC_BLK);
    chk("abc hold valid", 512'({blk_valid, readout}), 512'(2'b11));
    in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1; ask = 1'b1;
    @(negedge inclk); idle_inputs();
    chk("abc after ask", 512'({blk_valid, readout, in_ready}), 512'(3'b001));

    // ask pulses while no block is presented, including during PAD.
    ask = 1'b1;
    repeat (3) @(negedge inclk);
    ask = 1'b0;
    in_data = 8'h78; in_valid = 1'b1;
    @(negedge inclk); in_data = 8'h79; in_last = 1'b1;
    @(negedge inclk); idle_inputs(); ask = 1'b1;
    @(negedge inclk); ask = 1'b0;
    chk("xy ask in pad ignored", 512'({blk_valid, readout}), 512'(2'b11));
    chk("xy block", block_n, XY_BLK);
    ask = 1'b1;
    @(negedge inclk); idle_inputs();
    chk("xy after ask", 512'({blk_valid, in_ready}), 512'(2'b01));

    // Reset in the middle of a message leaves no trace.
    for (int i = 0; i < 30; i++) begin
      in_data = 8'(8'hA0 + i); in_valid = 1'b1;
      @(negedge inclk);
    end
    do_reset();
    @(negedge inclk);
    chk("midrst block_n", block_n, '0);
    run_msg(0, 3, nblk, llen);
    chk("midrst nblk", 512'(nblk), 512'(1));

    // Table of messages, back to back, through the scoreboard.
    for (int t = 0; t < 8; t++) begin
      run_msg(tv[t].pat, tv[t].n, nblk, llen);
      chk($sformatf("tv%0d nblocks", t), 512'(nblk), 512'(tv[t].exp_blocks));
      chk($sformatf("tv%0d length", t), 512'(llen), 512'(tv[t].exp_len));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
